// File: rtl/crc16_rx_ctrl.sv
// Receive-side sequencer for the USB data-packet CRC16 checker: strips the PID and feeds covered
// bits to the checker. The optional length check is compiled in with `define MAX_LEN_CHK_EN.
module crc16_rx_ctrl #(
    parameter int unsigned CNT_W     = 11,
    parameter int unsigned MAX_BYTES = 66
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             rx_start,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             eop,
    input  logic             crc_pass,
    output logic             crc_clear,
    output logic             crc_shift_en,
    output logic             crc_serial,
    output logic [7:0]       pid,
    output logic [CNT_W-1:0] byte_cnt,
    output logic             pkt_done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             pid_err,
    output logic             len_err
);

    typedef enum logic [2:0] {StIdle, StPid, StData, StSkip, StCheck} state_e;

    state_e           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       pid_q, pid_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic             pid_fail_q, pid_fail_d;
    logic             done_q, done_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic             pid_err_q, pid_err_d;

    logic [7:0] pid_next;
    logic       pid_good;
    logic       pid_is_data;
    logic       chk_ok;

    assign pid_next    = {bit_in, pid_q[7:1]};
    assign pid_good    = (pid_next[7:4] == ~pid_next[3:0]);
    assign pid_is_data = (pid_next[3:0] == 4'b0011) || (pid_next[3:0] == 4'b1011);
    // A good packet ends on a byte boundary and carries at least the two CRC bytes.
    assign chk_ok      = crc_pass && (bit_cnt_q == 3'd0) && (byte_cnt_q >= CNT_W'(2));

`ifdef MAX_LEN_CHK_EN
    logic len_fail_q, len_fail_d;
    logic len_err_q, len_err_d;
    logic len_over;

    assign len_over = (byte_cnt_q > CNT_W'(MAX_BYTES));
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        pid_d      = pid_q;
        byte_cnt_d = byte_cnt_q;
        pid_fail_d = pid_fail_q;
        done_d     = 1'b0;
        ok_d       = 1'b0;
        err_d      = 1'b0;
        pid_err_d  = 1'b0;
`ifdef MAX_LEN_CHK_EN
        len_fail_d = len_fail_q;
        len_err_d  = 1'b0;
`endif
        if (rx_start) begin
            state_d    = StPid;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = '0;
            pid_d      = 8'h00;
            pid_fail_d = 1'b0;
`ifdef MAX_LEN_CHK_EN
            len_fail_d = 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: ;
                StPid: begin
                    if (eop) begin
                        state_d   = StIdle;
                        done_d    = 1'b1;
                        pid_err_d = 1'b1;
                    end else if (bit_valid) begin
                        pid_d     = pid_next;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (!pid_good) begin
                                state_d    = StSkip;
                                pid_fail_d = 1'b1;
                            end else if (pid_is_data) begin
                                state_d = StData;
                            end else begin
                                state_d = StSkip;
                            end
                        end
                    end
                end
                StData: begin
                    if (bit_valid) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if ((bit_cnt_q == 3'd7) && (byte_cnt_q != '1)) begin
                            byte_cnt_d = byte_cnt_q + CNT_W'(1);
                        end
                    end
                    if (eop) begin
                        state_d = StCheck;
                    end
`ifdef MAX_LEN_CHK_EN
                    else if (len_over) begin
                        state_d    = StSkip;
                        len_fail_d = 1'b1;
                    end
`endif
                end
                StCheck: begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    ok_d    = chk_ok;
                    err_d   = !chk_ok;
`ifdef MAX_LEN_CHK_EN
                    if (len_over) begin
                        ok_d      = 1'b0;
                        err_d     = 1'b1;
                        len_err_d = 1'b1;
                    end
`endif
                end
                StSkip: begin
                    if (eop) begin
                        state_d   = StIdle;
                        done_d    = 1'b1;
                        pid_err_d = pid_fail_q;
`ifdef MAX_LEN_CHK_EN
                        err_d     = len_fail_q;
                        len_err_d = len_fail_q;
`endif
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 3'd0;
            pid_q      <= 8'h00;
            byte_cnt_q <= '0;
            pid_fail_q <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            pid_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            pid_q      <= pid_d;
            byte_cnt_q <= byte_cnt_d;
            pid_fail_q <= pid_fail_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            pid_err_q  <= pid_err_d;
        end
    end

`ifdef MAX_LEN_CHK_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            len_fail_q <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            len_fail_q <= len_fail_d;
            len_err_q  <= len_err_d;
        end
    end

    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif

    assign crc_clear    = (state_q == StIdle) || rx_start;
    assign crc_shift_en = (state_q == StData) && bit_valid;
    assign crc_serial   = bit_in;
    assign pid          = pid_q;
    assign byte_cnt     = byte_cnt_q;
    assign pkt_done     = done_q;
    assign crc_ok       = ok_q;
    assign crc_err      = err_q;
    assign pid_err      = pid_err_q;

endmodule

// File: tb/tb_crc16_rx_ctrl.sv
// Scoreboard bench for crc16_rx_ctrl: a bench-side CRC16 checker drives crc_pass, and expected
// verdicts come from a byte-level packet model.
module tb_crc16_rx_ctrl;

    localparam int CNT_W = 11;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic             rx_start = 1'b0;
    logic             bit_valid = 1'b0;
    logic             bit_in = 1'b0;
    logic             eop = 1'b0;
    logic             crc_pass;
    logic             crc_clear, crc_shift_en, crc_serial;
    logic [7:0]       pid;
    logic [CNT_W-1:0] byte_cnt;
    logic             pkt_done, crc_ok, crc_err, pid_err, len_err;

    crc16_rx_ctrl #(.CNT_W(CNT_W), .MAX_BYTES(66)) dut (
        .clk(clk), .n_rst(n_rst), .rx_start(rx_start), .bit_valid(bit_valid), .bit_in(bit_in),
        .eop(eop), .crc_pass(crc_pass), .crc_clear(crc_clear), .crc_shift_en(crc_shift_en),
        .crc_serial(crc_serial), .pid(pid), .byte_cnt(byte_cnt), .pkt_done(pkt_done),
        .crc_ok(crc_ok), .crc_err(crc_err), .pid_err(pid_err), .len_err(len_err)
    );

    always #5 clk = ~clk;

    // Serial USB CRC16 checker; a correct packet leaves the residual 16'h800d.
    logic [15:0] q_chk;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) q_chk <= 16'hffff;
        else if (crc_clear) q_chk <= 16'hffff;
        else if (crc_shift_en)
            q_chk <= {q_chk[14:0], 1'b0} ^ ((crc_serial ^ q_chk[15]) ? 16'h8005 : 16'h0000);
    end
    assign crc_pass = (q_chk == 16'h800d);

    typedef struct {
        logic       ok, err, perr, lerr;
        logic [7:0] pid;
        int         bytes;
        int         shifts;
    } exp_t;

    exp_t sb[$];
    logic tx[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   shifts_seen = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, req);
    endtask

    function automatic logic [15:0] crc16_of(input logic [7:0] d[$]);
        logic [15:0] r;
        logic        fb;
        r = 16'hffff;
        foreach (d[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = d[i][k] ^ r[0];
                r  = r >> 1;
                if (fb) r = r ^ 16'ha001;
            end
        end
        return ~r;
    endfunction

    function automatic exp_t model(input logic b[$]);
        exp_t        e;
        logic [7:0]  p;
        logic [7:0]  bytes[$];
        logic [7:0]  payload[$];
        logic [7:0]  cur;
        logic [15:0] c;
        int          n, cov, nb;
        e = '{ok: 1'b0, err: 1'b0, perr: 1'b0, lerr: 1'b0, pid: 8'h00, bytes: 0, shifts: 0};
        n = b.size();
        if (n < 8) begin
            for (int i = 0; i < n; i++) e.pid[i + 8 - n] = b[i];
            e.perr = 1'b1;
            return e;
        end
        for (int i = 0; i < 8; i++) p[i] = b[i];
        e.pid = p;
        if (p[7:4] != ~p[3:0]) begin
            e.perr = 1'b1;
        end else if (p[3:0] == 4'h3 || p[3:0] == 4'hb) begin
            cov      = n - 8;
            nb       = cov / 8;
            e.shifts = cov;
            e.bytes  = nb;
            for (int j = 0; j < nb; j++) begin
                for (int k = 0; k < 8; k++) cur[k] = b[8 + 8 * j + k];
                bytes.push_back(cur);
            end
            e.err = 1'b1;
            if (cov % 8 == 0 && nb >= 2) begin
                for (int j = 0; j < nb - 2; j++) payload.push_back(bytes[j]);
                c = crc16_of(payload);
                if (bytes[nb - 2] == c[7:0] && bytes[nb - 1] == c[15:8]) begin
                    e.ok  = 1'b1;
                    e.err = 1'b0;
                end
            end
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_byte(input logic [7:0] b);
        for (int k = 0; k < 8; k++) tx.push_back(b[k]);
    endtask

    task automatic add_crc_pkt(input logic [7:0] p, input int len);
        logic [7:0]  d[$];
        logic [15:0] c;
        tx.delete();
        add_byte(p);
        for (int i = 0; i < len; i++) begin
            d.push_back(8'($urandom_range(0, 255)));
            add_byte(d[i]);
        end
        c = crc16_of(d);
        add_byte(c[7:0]);
        add_byte(c[15:8]);
    endtask

    // Drives the current tx bits; eop rides on the last strobe only once past the PID.
    task automatic send(input bit eop_last, input bit do_eop);
        bit with_last;
        with_last = eop_last && do_eop && (tx.size() > 8);
        rx_start = 1'b1;
        tick();
        rx_start = 1'b0;
        foreach (tx[i]) begin
            repeat ($urandom_range(0, 1)) tick();
            bit_valid = 1'b1;
            bit_in    = tx[i];
            if (with_last && i == tx.size() - 1) eop = 1'b1;
            tick();
            bit_valid = 1'b0;
            eop       = 1'b0;
        end
        if (do_eop && !with_last) begin
            repeat ($urandom_range(0, 1)) tick();
            eop = 1'b1;
            tick();
            eop = 1'b0;
        end
    endtask

    task automatic run_pkt(input bit eop_last);
        sb.push_back(model(tx));
        send(eop_last, 1'b1);
        repeat (4) tick();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (pkt_done) begin
            if (sb.size() == 0) begin
                check("unexpected verdict", 1, 0);
            end else begin
                e = sb.pop_front();
                check("verdict ok/err/pid/len", {crc_ok, crc_err, pid_err, len_err},
                      {e.ok, e.err, e.perr, e.lerr});
                check("pid", pid, e.pid);
                check("byte_cnt", byte_cnt, e.bytes);
                check("shift strobes", shifts_seen, e.shifts);
            end
        end
        if (!n_rst || rx_start) shifts_seen = 0;
        else if (crc_shift_en) shifts_seen++;
    end

    initial begin
        logic [7:0] p;
        int         kind, nb, idx;
        repeat (3) tick();
        @(negedge clk);
        check("reset pid", pid, 8'h00);
        check("reset byte_cnt", byte_cnt, 0);
        check("reset flags", {pkt_done, crc_ok, crc_err, pid_err, len_err}, 5'b0);
        check("reset crc_clear", crc_clear, 1);
        n_rst = 1'b1;
        tick();

        tx.delete(); add_byte(8'hc3); add_byte(8'h00); add_byte(8'h00); run_pkt(1'b0);
        tx.delete(); add_byte(8'hc3); add_byte(8'h00); add_byte(8'h01); run_pkt(1'b0);
        tx.delete(); add_byte(8'h69); add_byte(8'h12); add_byte(8'h34); run_pkt(1'b0);
        tx.delete(); add_byte(8'hc4); add_byte(8'h55); run_pkt(1'b0);
        tx.delete(); add_byte(8'hc3); tx = tx[0:4]; run_pkt(1'b0);
        tx.delete(); add_byte(8'hc3); add_byte(8'h00); add_byte(8'h00);
        repeat (3) tx.push_back(1'b0);
        run_pkt(1'b1);
        tx.delete(); add_byte(8'hc3); add_byte(8'h00); run_pkt(1'b0);

        // Abort by a new SYNC mid-DATA, then a clean packet.
        tx.delete(); add_byte(8'hc3); add_byte(8'h00); add_byte(8'h5a);
        send(1'b0, 1'b0);
        tx.delete(); add_byte(8'hc3); add_byte(8'h00); add_byte(8'h00); run_pkt(1'b0);

        // Async reset mid-DATA, then a clean packet.
        tx.delete(); add_byte(8'hc3); add_byte(8'h00); add_byte(8'h5a);
        send(1'b0, 1'b0);
        n_rst = 1'b0;
        tick();
        @(negedge clk);
        check("mid-packet reset pid", pid, 8'h00);
        n_rst = 1'b1;
        tick();
        tx.delete(); add_byte(8'hc3); add_byte(8'h00); add_byte(8'h00); run_pkt(1'b1);

        // Strobes and eop in IDLE are ignored; pid/byte_cnt hold.
        repeat (5) begin
            bit_valid = 1'b1; bit_in = 1'b1; tick();
            bit_valid = 1'b0; eop = 1'b1; tick(); eop = 1'b0;
        end
        @(negedge clk);
        check("idle hold pid", pid, 8'hc3);
        check("idle hold byte_cnt", byte_cnt, 2);

        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 6);
            p    = ($urandom_range(0, 1) != 0) ? 8'hc3 : 8'h4b;
            case (kind)
                0, 1: add_crc_pkt(p, $urandom_range(0, 4));
                2: begin
                    add_crc_pkt(p, $urandom_range(0, 3));
                    idx = $urandom_range(8, tx.size() - 1);
                    tx[idx] = ~tx[idx];
                end
                3: begin
                    do p[3:0] = 4'($urandom_range(0, 15));
                    while (p[3:0] == 4'h3 || p[3:0] == 4'hb);
                    p[7:4] = ~p[3:0];
                    tx.delete(); add_byte(p);
                    repeat ($urandom_range(0, 20)) tx.push_back(1'($urandom_range(0, 1)));
                end
                4: begin
                    do p = 8'($urandom_range(0, 255)); while (p[7:4] == ~p[3:0]);
                    tx.delete(); add_byte(p);
                    repeat ($urandom_range(0, 20)) tx.push_back(1'($urandom_range(0, 1)));
                end
                5: begin
                    tx.delete();
                    repeat ($urandom_range(0, 7)) tx.push_back(1'($urandom_range(0, 1)));
                end
                default: begin
                    if ($urandom_range(0, 1) != 0) begin
                        add_crc_pkt(p, $urandom_range(0, 2));
                        repeat ($urandom_range(1, 7)) tx.push_back(1'($urandom_range(0, 1)));
                    end else begin
                        tx.delete(); add_byte(p);
                        nb = $urandom_range(0, 1);
                        repeat (nb) add_byte(8'($urandom_range(0, 255)));
                    end
                end
            endcase
            run_pkt(1'($urandom_range(0, 1)));
        end

        for (int w = 0; w < 20 && sb.size() != 0; w++) tick();
        check("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/crc16_rx_ctrl.md
Name: crc16_rx_ctrl

Overview:
Receive-side sequencer for the 16-bit USB data-packet CRC checker. Tracks packet framing from the RX bit decoder: SYNC detect, unstuffed bit strobes, and EOP. Separates the PID byte, which CRC16 does not cover, from the covered payload, then drives the checker's clear/shift_en/serial_in. At EOP it reports a single pass/fail verdict to the endpoint/protocol controller.

Parameters:
CNT_W, 11, width of byte counter (covers 1023 payload + 2 CRC bytes)
MAX_BYTES, 66, max covered bytes (payload + CRC) when length check is compiled in

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
rx_start  input  1  one-cycle pulse: SYNC detected, new packet begins
bit_valid  input  1  one-cycle strobe: bit_in holds a decoded, unstuffed bit
bit_in  input  1  decoded bit, LSB-first order
eop  input  1  one-cycle pulse: end of packet
crc_pass  input  1  checker residual match (Q == 16'h800d)
crc_clear  output  1  checker clear (Q <= 16'hffff)
crc_shift_en  output  1  checker shift enable
crc_serial  output  1  checker serial_in
pid  output  8  last received PID byte
byte_cnt  output  CNT_W  covered bytes received in current/last packet
pkt_done  output  1  one-cycle pulse: verdict valid
crc_ok  output  1  one-cycle pulse with pkt_done: data packet good
crc_err  output  1  one-cycle pulse with pkt_done: data packet bad
pid_err  output  1  one-cycle pulse with pkt_done: PID check failed or packet truncated in PID
len_err  output  1  one-cycle pulse with pkt_done: length overflow (0 without macro)

Behaviour:
- Reset: state IDLE; pid=8'h00, byte_cnt=0, bit counter=0; pkt_done/crc_ok/crc_err/pid_err/len_err=0.
- States: IDLE, PID, DATA, SKIP, CHECK.
- crc_clear = (state==IDLE) | rx_start (combinational). Checker is held at FFFF between packets.
- crc_shift_en = (state==DATA) & bit_valid; crc_serial = bit_in. Both combinational, same cycle as strobe.
- IDLE: rx_start -> PID; bit counter=0, byte_cnt=0, pid=0.
- PID: on bit_valid, pid <= {bit_in, pid[7:1]}, bit counter++. On the 8th bit, evaluate the assembled byte:
  - upper nibble != ~lower nibble -> SKIP, flag PID error.
  - lower nibble 4'b0011 (DATA0) or 4'b1011 (DATA1) -> DATA, bit counter=0.
  - otherwise -> SKIP, non-data, no verdict.
- eop in PID -> IDLE with pkt_done+pid_err.
- DATA: bit counter 0..7 wraps; each wrap increments byte_cnt, saturating at all-ones. eop -> CHECK. If eop coincides with bit_valid, that bit is shifted first.
- CHECK (one cycle; checker now holds final Q): ok = crc_pass & (bit counter==0) & (byte_cnt>=2). Register pkt_done=1 with crc_ok=ok, crc_err=~ok -> IDLE.
- SKIP: bits ignored. On eop -> IDLE with pkt_done=1; pid_err=1 if PID check failed; crc_ok=crc_err=0.
- Status outputs are registered and high exactly one cycle. Latency: eop sampled at edge N, verdict high in the cycle after edge N+2 (data) or N+1 (SKIP/PID abort).
- rx_start in any non-IDLE state: abort without verdict, restart at PID. Checker cleared the same cycle.
- bit_valid/eop ignored in IDLE. pid and byte_cnt hold after a packet until next rx_start.
- Async reset mid-packet: immediate return to IDLE, no verdict.

Optional Feature:
MAX_LEN_CHK_EN: when defined, byte_cnt > MAX_BYTES in DATA -> SKIP with a length-error flag. At eop, pkt_done+crc_err+len_err pulse. When undefined, no length check and len_err tied 0.

Test Plan:
- rx_start, bits of C3 00 00 LSB-first, eop -> crc_shift_en high for exactly 16 strobes; pkt_done+crc_ok, byte_cnt=2, pid=8'hC3.
- Same with last byte 01 -> pkt_done+crc_err, crc_ok=0.
- PID 69 (IN) + 16 bits, eop -> crc_shift_en never high, pkt_done with crc_ok=crc_err=pid_err=0.
- PID C4 -> pkt_done+pid_err at eop; eop after 5 PID bits -> pkt_done+pid_err.
- C3 00 00 plus 3 extra bits, eop -> crc_err; C3 00 then eop -> crc_err (byte_cnt=1).
- rx_start mid-DATA, or n_rst pulse mid-DATA, then clean C3 00 00 -> no verdict for aborted packet, crc_ok for second. With MAX_LEN_CHK_EN and MAX_BYTES=2: C3 00 00 00 -> len_err+crc_err.
